// File: rtl/cordic4_pkg.sv
// Shared definitions for the 4-bit iterative CORDIC rotation engine:
// data width, angle scaling, arctangent table and FSM state encoding.
package cordic4_pkg;

    localparam int W = 4;
    // Angles are two's complement with 1 LSB = pi/ANGLE_LSB_DIV radians.
    localparam int ANGLE_LSB_DIV = 16;
    localparam int LUT_DEPTH = 4;
    localparam int SHW = 2;

    typedef logic [W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        word_t x;
        word_t y;
        word_t z;
    } vec_t;

    // atan(2^-i) expressed in pi/16 units, rounded to the nearest LSB.
    function automatic word_t atan_lut(input logic [SHW-1:0] idx);
        case (idx)
            2'd0:    return word_t'(4);
            2'd1:    return word_t'(2);
            default: return word_t'(1);
        endcase
    endfunction

endpackage

// File: rtl/cordic4_rot_seq_if.sv
// Start/done handshake plus operand and result buses of the rotation engine.
interface cordic4_rot_seq_if;
    import cordic4_pkg::*;

    logic  start;
    word_t X_in;
    word_t Y_in;
    word_t Z_in;
    logic  busy;
    logic  done;
    word_t X_out;
    word_t Y_out;
    word_t Z_out;

    modport master (
        output start, X_in, Y_in, Z_in,
        input  busy, done, X_out, Y_out, Z_out
    );

    modport slave (
        input  start, X_in, Y_in, Z_in,
        output busy, done, X_out, Y_out, Z_out
    );

endinterface

// File: rtl/cordic4_ashift.sv
// Combinational arithmetic right shift of a WIDTH-bit word by a 2-bit amount.
module cordic4_ashift
    import cordic4_pkg::*;
#(
    parameter int WIDTH = W
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   amt,
    output logic [WIDTH-1:0] shifted
);

    localparam int IDXW = $clog2(2 * WIDTH);

    // Sign-extended copy so every output bit is a plain indexed select.
    logic [2*WIDTH-1:0] ext;
    assign ext = {{WIDTH{data[WIDTH-1]}}, data};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [IDXW-1:0] idx;
            assign idx        = IDXW'(gi) + IDXW'(amt);
            assign shifted[gi] = ext[idx];
        end
    endgenerate

endmodule

// File: rtl/cordic4_rot_seq.sv
// Iterative CORDIC rotation: one micro-rotation per clock, start/done handshake,
// results held in the working registers until the next accepted start.
module cordic4_rot_seq
    import cordic4_pkg::*;
#(
    parameter int ITERS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cordic4_rot_seq_if.slave  bus
);

    localparam logic [SHW-1:0] LAST_ITER = SHW'(ITERS - 1);

    state_t         state_reg, state_next;
    vec_t           vec_reg, vec_next;
    logic [SHW-1:0] iter_reg, iter_next;

    word_t sx, sy;
    word_t angle;
    logic  z_neg;
    logic  accept;
    vec_t  rotated;
    vec_t  operands;

    cordic4_ashift #(.WIDTH(W)) u_shift_x (
        .data    (vec_reg.x),
        .amt     (iter_reg),
        .shifted (sx)
    );

    cordic4_ashift #(.WIDTH(W)) u_shift_y (
        .data    (vec_reg.y),
        .amt     (iter_reg),
        .shifted (sy)
    );

    assign angle    = atan_lut(iter_reg);
    assign z_neg    = vec_reg.z[W-1];
    assign operands = '{x: bus.X_in, y: bus.Y_in, z: bus.Z_in};

    // Rotate toward Z=0: the sign of the residual angle picks the direction.
    always_comb begin
        rotated = vec_reg;
        if (z_neg) begin
            rotated.x = vec_reg.x + sy;
            rotated.y = vec_reg.y - sx;
            rotated.z = vec_reg.z + angle;
        end else begin
            rotated.x = vec_reg.x - sy;
            rotated.y = vec_reg.y + sx;
            rotated.z = vec_reg.z - angle;
        end
    end

    // start is only honoured when no operation is in flight.
    assign accept = bus.start && ((state_reg == IDLE) || (state_reg == DONE));

    always_comb begin
        state_next = state_reg;
        vec_next   = vec_reg;
        iter_next  = iter_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    vec_next   = operands;
                    iter_next  = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                vec_next  = rotated;
                iter_next = iter_reg + 1'b1;
                if (iter_reg == LAST_ITER) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    vec_next   = operands;
                    iter_next  = '0;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            vec_reg   <= '0;
            iter_reg  <= '0;
        end else begin
            state_reg <= state_next;
            vec_reg   <= vec_next;
            iter_reg  <= iter_next;
        end
    end

    assign bus.busy  = (state_reg == RUN);
    assign bus.done  = (state_reg == DONE);
    assign bus.X_out = vec_reg.x;
    assign bus.Y_out = vec_reg.y;
    assign bus.Z_out = vec_reg.z;

endmodule

// File: tb/tb_cordic4_rot_seq.sv
// Directed bench for cordic4_rot_seq: handshake timing, per-iteration values,
// wrap-around, back-to-back operation and asynchronous reset mid-operation.
module tb_cordic4_rot_seq;
    import cordic4_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cordic4_rot_seq_if bus();

    cordic4_rot_seq #(.ITERS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {busy, done, X_out, Y_out, Z_out}
    function automatic logic [13:0] obs();
        return {bus.busy, bus.done, bus.X_out, bus.Y_out, bus.Z_out};
    endfunction

    // Presents operands with start for one edge; returns at the negedge
    // following the accepting edge (first RUN cycle).
    task automatic load(input logic [3:0] x, input logic [3:0] y, input logic [3:0] z);
        @(negedge clk);
        bus.start = 1'b1;
        bus.X_in  = x;
        bus.Y_in  = y;
        bus.Z_in  = z;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.X_in  = '0;
        bus.Y_in  = '0;
        bus.Z_in  = '0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 14'h0) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", obs(), 14'h0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 14'h0) begin
                errors++;
                $display("FAIL reset_idle_%0d: got %h want %h", s, obs(), 14'h0);
            end
        end
        $display("reset: busy=%0b done=%0b X=%h Y=%h Z=%h", bus.busy, bus.done,
                 bus.X_out, bus.Y_out, bus.Z_out);
    endtask

    task automatic test_nominal();
        logic [13:0] exp_seq [4];
        exp_seq = '{{1'b1, 1'b0, 4'h4, 4'h4, 4'h0},
                    {1'b1, 1'b0, 4'h2, 4'h6, 4'hE},
                    {1'b1, 1'b0, 4'h3, 4'h6, 4'hF},
                    {1'b0, 1'b1, 4'h3, 4'h6, 4'h0}};
        load(4'h4, 4'h0, 4'h4);
        checks++;
        if (obs() !== {1'b1, 1'b0, 4'h4, 4'h0, 4'h4}) begin
            errors++;
            $display("FAIL nominal_load: got %h want %h", obs(), {1'b1, 1'b0, 4'h4, 4'h0, 4'h4});
        end
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_seq[s]) begin
                errors++;
                $display("FAIL nominal_iter%0d: got %h want %h", s, obs(), exp_seq[s]);
            end
        end
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            checks++;
            if (obs() !== {1'b0, 1'b0, 4'h3, 4'h6, 4'h0}) begin
                errors++;
                $display("FAIL nominal_hold%0d: got %h want %h", s, obs(), {1'b0, 1'b0, 4'h3, 4'h6, 4'h0});
            end
        end
        $display("nominal: X=%h Y=%h Z=%h", bus.X_out, bus.Y_out, bus.Z_out);
    endtask

    task automatic test_wrap();
        logic [13:0] exp_seq [4];
        exp_seq = '{{1'b1, 1'b0, 4'h0, 4'hE, 4'h0},
                    {1'b1, 1'b0, 4'h1, 4'hE, 4'hE},
                    {1'b1, 1'b0, 4'h0, 4'hE, 4'hF},
                    {1'b0, 1'b1, 4'hF, 4'hE, 4'h0}};
        load(4'h7, 4'h7, 4'h4);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_seq[s]) begin
                errors++;
                $display("FAIL wrap_iter%0d: got %h want %h", s, obs(), exp_seq[s]);
            end
        end
        $display("wrap: X=%h Y=%h Z=%h", bus.X_out, bus.Y_out, bus.Z_out);
        @(negedge clk);
    endtask

    task automatic test_zero();
        logic [13:0] exp_seq [4];
        exp_seq = '{{1'b1, 1'b0, 4'h0, 4'h0, 4'hC},
                    {1'b1, 1'b0, 4'h0, 4'h0, 4'hE},
                    {1'b1, 1'b0, 4'h0, 4'h0, 4'hF},
                    {1'b0, 1'b1, 4'h0, 4'h0, 4'h0}};
        load(4'h0, 4'h0, 4'h0);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_seq[s]) begin
                errors++;
                $display("FAIL zero_iter%0d: got %h want %h", s, obs(), exp_seq[s]);
            end
        end
        $display("zero: X=%h Y=%h Z=%h", bus.X_out, bus.Y_out, bus.Z_out);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int  done_count;
        logic exp_done;
        done_count = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.X_in  = 4'h4;
        bus.Y_in  = 4'h0;
        bus.Z_in  = 4'h4;
        for (int s = 1; s <= 15; s++) begin
            @(negedge clk);
            exp_done = ((s % 5) == 0);
            checks++;
            if ({bus.busy, bus.done} !== {~exp_done, exp_done}) begin
                errors++;
                $display("FAIL b2b_hs_step%0d: busy/done got %b%b want %b%b", s,
                         bus.busy, bus.done, ~exp_done, exp_done);
            end
            if (exp_done) begin
                done_count++;
                checks++;
                if ({bus.X_out, bus.Y_out, bus.Z_out} !== 12'h360) begin
                    errors++;
                    $display("FAIL b2b_result_step%0d: got %h want %h", s,
                             {bus.X_out, bus.Y_out, bus.Z_out}, 12'h360);
                end
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== {1'b0, 1'b0, 4'h3, 4'h6, 4'h0}) begin
            errors++;
            $display("FAIL b2b_idle: got %h want %h", obs(), {1'b0, 1'b0, 4'h3, 4'h6, 4'h0});
        end
        $display("back_to_back: ops=%0d X=%h Y=%h Z=%h", done_count, bus.X_out, bus.Y_out, bus.Z_out);
    endtask

    task automatic test_start_mid_run();
        load(4'h4, 4'h0, 4'h4);
        @(negedge clk);
        bus.start = 1'b1;
        bus.X_in  = 4'h7;
        bus.Y_in  = 4'h7;
        bus.Z_in  = 4'h4;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (obs() !== {1'b1, 1'b0, 4'h2, 4'h6, 4'hE}) begin
            errors++;
            $display("FAIL midrun_iter1: got %h want %h", obs(), {1'b1, 1'b0, 4'h2, 4'h6, 4'hE});
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs() !== {1'b0, 1'b1, 4'h3, 4'h6, 4'h0}) begin
            errors++;
            $display("FAIL midrun_result: got %h want %h", obs(), {1'b0, 1'b1, 4'h3, 4'h6, 4'h0});
        end
        $display("start_mid_run: X=%h Y=%h Z=%h", bus.X_out, bus.Y_out, bus.Z_out);
        @(negedge clk);
    endtask

    task automatic test_start_in_done();
        logic [13:0] exp_seq [4];
        exp_seq = '{{1'b1, 1'b0, 4'h0, 4'hE, 4'h0},
                    {1'b1, 1'b0, 4'h1, 4'hE, 4'hE},
                    {1'b1, 1'b0, 4'h0, 4'hE, 4'hF},
                    {1'b0, 1'b1, 4'hF, 4'hE, 4'h0}};
        load(4'h4, 4'h0, 4'h4);
        repeat (4) @(negedge clk);
        checks++;
        if (obs() !== {1'b0, 1'b1, 4'h3, 4'h6, 4'h0}) begin
            errors++;
            $display("FAIL done_first_result: got %h want %h", obs(), {1'b0, 1'b1, 4'h3, 4'h6, 4'h0});
        end
        bus.start = 1'b1;
        bus.X_in  = 4'h7;
        bus.Y_in  = 4'h7;
        bus.Z_in  = 4'h4;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (obs() !== {1'b1, 1'b0, 4'h7, 4'h7, 4'h4}) begin
            errors++;
            $display("FAIL done_reload: got %h want %h", obs(), {1'b1, 1'b0, 4'h7, 4'h7, 4'h4});
        end
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_seq[s]) begin
                errors++;
                $display("FAIL done_second_iter%0d: got %h want %h", s, obs(), exp_seq[s]);
            end
        end
        $display("start_in_done: X=%h Y=%h Z=%h", bus.X_out, bus.Y_out, bus.Z_out);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        load(4'h4, 4'h0, 4'h4);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 14'h0) begin
            errors++;
            $display("FAIL rstmid_async: got %h want %h", obs(), 14'h0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 14'h0) begin
                errors++;
                $display("FAIL rstmid_nodone%0d: got %h want %h", s, obs(), 14'h0);
            end
        end
        load(4'h4, 4'h0, 4'h4);
        repeat (4) @(negedge clk);
        checks++;
        if (obs() !== {1'b0, 1'b1, 4'h3, 4'h6, 4'h0}) begin
            errors++;
            $display("FAIL rstmid_rerun: got %h want %h", obs(), {1'b0, 1'b1, 4'h3, 4'h6, 4'h0});
        end
        $display("reset_mid_run: X=%h Y=%h Z=%h", bus.X_out, bus.Y_out, bus.Z_out);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_wrap();
        test_zero();
        test_back_to_back();
        test_start_mid_run();
        test_start_in_done();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cordic4_rot_seq.md
Name: cordic4_rot_seq

Overview:
Iterative 4-bit CORDIC rotation engine. It consumes the right-shifted X/Y terms produced by the per-iteration shifter stage and performs one micro-rotation per clock: add/subtract of the shifted cross term plus an angle-accumulator update. It sits downstream of the input vector/angle source and hands rotated X/Y to the output stage with a start/done handshake.

Parameters:
ITERS, 4, number of micro-rotations per operation; legal range 1..4, bounded by the angle LUT depth.

Ports:
clk      input   1  system clock, rising edge
rst_n    input   1  asynchronous active-low reset
start    input   1  request; sampled only when state is IDLE or DONE
X_in     input   4  initial X, two's complement
Y_in     input   4  initial Y, two's complement
Z_in     input   4  target angle, two's complement, 1 LSB = pi/16
busy     output  1  high while iterating
done     output  1  one-cycle pulse when results are valid
X_out    output  4  rotated X, two's complement
Y_out    output  4  rotated Y, two's complement
Z_out    output  4  residual angle, two's complement

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, iteration counter i=0.
  - X_out, Y_out, Z_out, busy and done all 0.
  - Reset mid-RUN aborts the operation with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge loads X_in/Y_in/Z_in into the working registers, sets i=0 and moves to RUN.
  - start=0 holds IDLE.
- RUN, one micro-rotation per edge, with sx = X>>>i and sy = Y>>>i (arithmetic shift, sign fill):
  - If Z[3]==0: X <= X - sy; Y <= Y + sx; Z <= Z - ATAN_LUT[i].
  - If Z[3]==1: X <= X + sy; Y <= Y - sx; Z <= Z + ATAN_LUT[i].
  - i increments each edge. The edge that performs iteration ITERS-1 moves the FSM to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - start=1 here is accepted: operands load, state goes to RUN, done drops next cycle (back-to-back operation).
  - Otherwise the FSM returns to IDLE.
- Outputs:
  - busy=1 exactly while state==RUN.
  - X_out/Y_out/Z_out are the working registers. They are valid in DONE and held unchanged in IDLE until the next accepted start.
- Latency: start sampled at edge k, done high during the cycle after edge k+ITERS. Throughput is one operation per ITERS+1 cycles.
- start while in RUN is ignored; operands are not reloaded.
- Arithmetic:
  - All adds/subtracts are 4-bit, wrap modulo 16.
  - No saturation and no overflow flag.
  - No gain (K) compensation; the ~1.64 gain is the consumer's responsibility.
- Shift amount i >= 3 on a 4-bit value yields 0 for non-negative inputs and -1 (4'hF) for negative inputs.

Decomposition:
- Shared package cordic4_pkg:
  - Data width constant W=4 and angle LSB definition (pi/16).
  - ATAN_LUT[0..3] = 4, 2, 1, 1.
  - FSM state typedef {IDLE, RUN, DONE}.
- One sub-module, cordic4_ashift: combinational W-bit arithmetic right shift by a 2-bit amount.
  - Instantiated twice, once for X and once for Y.
  - This is the variable-shift generalisation of the fixed shifter stage.

Test Plan:
- Reset values: assert rst_n=0 -> busy=0, done=0, X_out=Y_out=Z_out=0. Release rst_n, hold start=0 for 5 cycles -> outputs stay 0, state stays IDLE.
- Nominal rotation: X_in=4, Y_in=0, Z_in=4, ITERS=4, start pulsed at edge k.
  - Required: busy high for 4 cycles.
  - done high for exactly one cycle after edge k+4, with X_out=3, Y_out=6, Z_out=0.
  - Intermediate values: (4,4,0), (2,6,-2), (3,6,-1), (3,6,0).
- Wrap-around: X_in=7, Y_in=7, Z_in=4.
  - Required: Y wraps to -2 after iteration 0.
  - Final X_out=4'hF, Y_out=4'hE, Z_out=0.
- Zero vector: X_in=Y_in=Z_in=0.
  - Required: Z sequence -4, -2, -1, 0.
  - Final X_out=Y_out=Z_out=0.
- Handshake corners:
  - start held high continuously -> back-to-back ops, done every 5th cycle.
  - start asserted mid-RUN with different operands -> ignored; result matches the first operands.
  - start=1 in DONE -> new op begins with no IDLE cycle.
- Reset mid-operation: rst_n=0 asynchronously at iteration 2 -> immediately busy=0, outputs 0, no done pulse. A subsequent start runs a clean, correct operation.
